// File: rtl/spi_flash_rdseq.sv
// Multi-word flash read sequencer in front of spi_master_fl: issues one read frame per word, buffers results in a FIFO.
// Define SPI_RDSEQ_FASTREAD_EN to use FAST READ (0x0B, 8 dummy cycles) instead of READ (0x03, no dummy).
module spi_flash_rdseq #(
    parameter int unsigned FIFO_AW      = 2,
    parameter logic [2:0]  READ_CTYP    = 3'b001,
    parameter logic [9:0]  FRAME_STRUCT = 10'h000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [15:0] req_nwords,
    input  logic        req_4byte,
    input  logic        abort,
    output logic [31:0] rd_data,
    output logic        rd_valid,
    input  logic        rd_ready,
    output logic        busy,
    output logic        done,
    output logic        ctrl_validflag,
    input  logic        ctrl_tready,
    input  logic [31:0] ctrl_data_out,
    output logic [31:0] ctrl_address,
    output logic [7:0]  ctrl_command,
    output logic [2:0]  ctrl_commtype,
    output logic [6:0]  ctrl_ndata_bits,
    output logic [3:0]  ctrl_dummy_cycles,
    output logic [9:0]  ctrl_frame_struct,
    output logic        ctrl_fourbyteaddr_on,
    output logic        ctrl_dtr_en,
    output logic [1:0]  ctrl_xipbit_en,
    output logic [1:0]  ctrl_spimode
);

`ifdef SPI_RDSEQ_FASTREAD_EN
    localparam logic [7:0] READ_OP   = 8'h0B;
    localparam logic [3:0] READ_DUMMY = 4'd8;
`else
    localparam logic [7:0] READ_OP   = 8'h03;
    localparam logic [3:0] READ_DUMMY = 4'd0;
`endif

    localparam int unsigned      DEPTH   = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] DEPTH_C = (FIFO_AW + 1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, ISSUE, WAITACK, WAITDONE} state_t;

    state_t             state;
    logic [15:0]        remaining;
    logic               abort_pend;
    logic [31:0]        mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW-1:0] rd_ptr;
    logic [FIFO_AW:0]   count;

    logic [31:0] start_addr_c;
    logic [31:0] next_addr_c;
    logic        space_c;
    logic        pop_c;
    logic        capture_c;
    logic        kill_c;
    logic        push_c;
    logic        flush_c;

    assign ctrl_command      = READ_OP;
    assign ctrl_dummy_cycles = READ_DUMMY;
    assign ctrl_commtype     = READ_CTYP;
    assign ctrl_ndata_bits   = 7'd32;
    assign ctrl_frame_struct = FRAME_STRUCT;
    assign ctrl_dtr_en       = 1'b0;
    assign ctrl_xipbit_en    = 2'b00;
    assign ctrl_spimode      = 2'b00;

    assign rd_valid = (count != '0);
    assign rd_data  = mem[rd_ptr];

    // Datapath decode; an aborted in-flight word is dropped together with the FIFO contents.
    always_comb begin
        start_addr_c = req_addr & (req_4byte ? 32'hFFFF_FFFC : 32'h00FF_FFFC);
        next_addr_c  = (ctrl_address + 32'd4) & (ctrl_fourbyteaddr_on ? 32'hFFFF_FFFC : 32'h00FF_FFFC);
        space_c      = (count < DEPTH_C);
        pop_c        = rd_valid && rd_ready;
        capture_c    = (state == WAITDONE) && ctrl_tready;
        kill_c       = abort || abort_pend;
        push_c       = capture_c && !kill_c;
        flush_c      = (capture_c && kill_c)
                    || ((state == ISSUE) && abort && !(ctrl_validflag && ctrl_tready));
    end

    // Command sequencer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state                <= IDLE;
            req_ready            <= 1'b1;
            busy                 <= 1'b0;
            done                 <= 1'b0;
            ctrl_validflag       <= 1'b0;
            ctrl_address         <= 32'h0;
            ctrl_fourbyteaddr_on <= 1'b0;
            remaining            <= 16'h0;
            abort_pend           <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        ctrl_address         <= start_addr_c;
                        ctrl_fourbyteaddr_on <= req_4byte;
                        remaining            <= req_nwords;
                        abort_pend           <= 1'b0;
                        if (req_nwords == 16'h0) begin
                            done <= 1'b1;
                        end else begin
                            state          <= ISSUE;
                            req_ready      <= 1'b0;
                            busy           <= 1'b1;
                            ctrl_validflag <= space_c;
                        end
                    end
                end
                ISSUE: begin
                    if (ctrl_validflag && ctrl_tready) begin
                        ctrl_validflag <= 1'b0;
                        abort_pend     <= abort;
                        state          <= WAITACK;
                    end else if (abort) begin
                        ctrl_validflag <= 1'b0;
                        state          <= IDLE;
                        req_ready      <= 1'b1;
                        busy           <= 1'b0;
                        done           <= 1'b1;
                    end else begin
                        // Validflag only goes out once a FIFO slot is free for the returning word.
                        ctrl_validflag <= space_c;
                    end
                end
                WAITACK: begin
                    if (abort) abort_pend <= 1'b1;
                    if (!ctrl_tready) state <= WAITDONE;
                end
                WAITDONE: begin
                    if (ctrl_tready) begin
                        if (kill_c || (remaining == 16'd1)) begin
                            state      <= IDLE;
                            req_ready  <= 1'b1;
                            busy       <= 1'b0;
                            done       <= 1'b1;
                            abort_pend <= 1'b0;
                        end else begin
                            state        <= ISSUE;
                            ctrl_address <= next_addr_c;
                            remaining    <= remaining - 16'd1;
                        end
                    end else if (abort) begin
                        abort_pend <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Read FIFO.
    always_ff @(posedge clk) begin
        if (rst || flush_c) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_c) begin
                mem[wr_ptr] <= ctrl_data_out;
                wr_ptr      <= wr_ptr + FIFO_AW'(1);
            end
            if (pop_c) rd_ptr <= rd_ptr + FIFO_AW'(1);
            if (push_c && !pop_c)      count <= count + (FIFO_AW + 1)'(1);
            else if (!push_c && pop_c) count <= count - (FIFO_AW + 1)'(1);
        end
    end

endmodule
